// File: rtl/bi_link_pkg.sv
// Shared types and counter widths for the arbitrated half-duplex BiNoC link.
//   link_state_t : arbitration FSM states
//   dir_t        : which endpoint owns (or will own) the link
//   BURST_W      : burst counter width, covers MAX_BURST up to 255
//   TURN_W       : turnaround counter width, covers TURN_CYC up to 15
package bi_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        A2B   = 2'd1,
        B2A   = 2'd2,
        DRAIN = 2'd3
    } link_state_t;

    typedef enum logic {
        DIR_A = 1'b0,
        DIR_B = 1'b1
    } dir_t;

    localparam int BURST_W = 8;
    localparam int TURN_W  = 4;

endpackage

// File: rtl/bi_link_stage.sv
// Single-entry registered stage shared by both link directions.
//   clk, rst_n    : link clock, async active-low reset (drops any held beat)
//   load          : capture load_data this cycle (wins over pop: pass-through)
//   load_from_b   : 1 = beat came from B (goes to A), 0 = from A (goes to B)
//   load_data     : beat payload
//   pop           : destination took the held beat
//   stg_valid     : a beat is held
//   stg_from_b    : source of the held beat
//   to_a_data     : last payload loaded toward A (held while not valid)
//   to_b_data     : last payload loaded toward B (held while not valid)
module bi_link_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_from_b,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop,
    output logic              stg_valid,
    output logic              stg_from_b,
    output logic [DATA_W-1:0] to_a_data,
    output logic [DATA_W-1:0] to_b_data
);

    // Two payload registers so each side's data output keeps its own last
    // value instead of showing beats that travelled the other way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid  <= 1'b0;
            stg_from_b <= 1'b0;
            to_a_data  <= '0;
            to_b_data  <= '0;
        end else if (load) begin
            stg_valid  <= 1'b1;
            stg_from_b <= load_from_b;
            if (load_from_b) begin
                to_a_data <= load_data;
            end else begin
                to_b_data <= load_data;
            end
        end else if (pop) begin
            stg_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bi_link_ctrl.sv
// Arbitrated controller for one half-duplex BiNoC channel between endpoint
// A and endpoint B. Picks the link direction, limits bursts while the other
// side waits, drains the stage and inserts a turnaround gap before reversal.
//   clk, rst_n               : link clock, async active-low reset
//   a_in_*  / b_in_*         : beats entering from A / B (valid is also the
//                              direction request)
//   a_out_* / b_out_*        : beats delivered to A / B
//   dir_a2b / dir_b2a        : current link owner (never both high)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, no owner yet; nothing accepted
// A2B   | A owns the link, A beats accepted toward B
// B2A   | B owns the link, B beats accepted toward A
// DRAIN | reversing: stage empties, then turnaround gap, then next_dir
module bi_link_ctrl
    import bi_link_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int TURN_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_in_data,
    input  logic              a_in_valid,
    output logic              a_in_ready,
    input  logic [DATA_W-1:0] b_in_data,
    input  logic              b_in_valid,
    output logic              b_in_ready,
    output logic [DATA_W-1:0] a_out_data,
    output logic              a_out_valid,
    input  logic              a_out_ready,
    output logic [DATA_W-1:0] b_out_data,
    output logic              b_out_valid,
    input  logic              b_out_ready,
    output logic              dir_a2b,
    output logic              dir_b2a
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    // The first DRAIN cycle with an empty stage already counts as a gap
    // cycle, so TURN_CYC=0 and TURN_CYC=1 both leave after one empty cycle.
    localparam logic [TURN_W-1:0]  TURN_LAST = (TURN_CYC == 0) ? '0 : TURN_W'(TURN_CYC - 1);

    link_state_t          state_q, state_d;
    dir_t                 next_dir_q, next_dir_d;
    dir_t                 prio_q, prio_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [TURN_W-1:0]    turn_cnt_q, turn_cnt_d;

    logic                 stg_valid;
    logic                 stg_from_b;
    logic                 stall;
    logic                 acc_a;
    logic                 acc_b;
    logic                 pop;

    bi_link_stage #(
        .DATA_W (DATA_W)
    ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (acc_a | acc_b),
        .load_from_b (acc_b),
        .load_data   (acc_b ? b_in_data : a_in_data),
        .pop         (pop),
        .stg_valid   (stg_valid),
        .stg_from_b  (stg_from_b),
        .to_a_data   (a_out_data),
        .to_b_data   (b_out_data)
    );

    // Owner yields when the other side is waiting and the owner has either
    // used up its burst or has nothing more to send.
    always_comb begin
        stall = 1'b0;
        if (state_q == A2B) begin
            stall = b_in_valid && ((burst_cnt_q == BURST_MAX) || !a_in_valid);
        end else if (state_q == B2A) begin
            stall = a_in_valid && ((burst_cnt_q == BURST_MAX) || !b_in_valid);
        end
    end

    assign a_in_ready  = (state_q == A2B) && !stall && (!stg_valid || b_out_ready);
    assign b_in_ready  = (state_q == B2A) && !stall && (!stg_valid || a_out_ready);
    assign acc_a       = a_in_ready && a_in_valid;
    assign acc_b       = b_in_ready && b_in_valid;

    assign b_out_valid = stg_valid && !stg_from_b;
    assign a_out_valid = stg_valid &&  stg_from_b;
    assign pop         = stg_from_b ? a_out_valid && a_out_ready : b_out_valid && b_out_ready;

    assign dir_a2b = (state_q == A2B) || ((state_q == DRAIN) && b_out_valid);
    assign dir_b2a = (state_q == B2A) || ((state_q == DRAIN) && a_out_valid);

    always_comb begin
        state_d     = state_q;
        next_dir_d  = next_dir_q;
        prio_d      = prio_q;
        burst_cnt_d = burst_cnt_q;
        turn_cnt_d  = turn_cnt_q;

        if ((acc_a || acc_b) && (burst_cnt_q != BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (a_in_valid && (!b_in_valid || (prio_q == DIR_A))) begin
                    state_d     = A2B;
                    burst_cnt_d = '0;
                end else if (b_in_valid) begin
                    state_d     = B2A;
                    burst_cnt_d = '0;
                end
            end
            A2B: begin
                if (stall) begin
                    state_d    = DRAIN;
                    next_dir_d = DIR_B;
                    prio_d     = DIR_B;
                    turn_cnt_d = '0;
                end
            end
            B2A: begin
                if (stall) begin
                    state_d    = DRAIN;
                    next_dir_d = DIR_A;
                    prio_d     = DIR_A;
                    turn_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!stg_valid) begin
                    if (turn_cnt_q == TURN_LAST) begin
                        state_d     = (next_dir_q == DIR_A) ? A2B : B2A;
                        burst_cnt_d = '0;
                        turn_cnt_d  = '0;
                    end else begin
                        turn_cnt_d = turn_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_dir_q  <= DIR_A;
            prio_q      <= DIR_A;
            burst_cnt_q <= '0;
            turn_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            next_dir_q  <= next_dir_d;
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

endmodule

// File: tb/tb_bi_link_ctrl.sv
module tb_bi_link_ctrl;

    localparam int DW = 32;
    localparam int MB = 2;
    localparam int TC = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] a_in_data = '0;
    logic          a_in_valid = 1'b0;
    logic          a_in_ready;
    logic [DW-1:0] b_in_data = '0;
    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [DW-1:0] a_out_data;
    logic          a_out_valid;
    logic          a_out_ready = 1'b0;
    logic [DW-1:0] b_out_data;
    logic          b_out_valid;
    logic          b_out_ready = 1'b0;
    logic          dir_a2b;
    logic          dir_b2a;

    always #5 clk = ~clk;

    bi_link_ctrl #(
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .TURN_CYC  (TC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_in_data   (a_in_data),
        .a_in_valid  (a_in_valid),
        .a_in_ready  (a_in_ready),
        .b_in_data   (b_in_data),
        .b_in_valid  (b_in_valid),
        .b_in_ready  (b_in_ready),
        .a_out_data  (a_out_data),
        .a_out_valid (a_out_valid),
        .a_out_ready (a_out_ready),
        .b_out_data  (b_out_data),
        .b_out_valid (b_out_valid),
        .b_out_ready (b_out_ready),
        .dir_a2b     (dir_a2b),
        .dir_b2a     (dir_b2a)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the link, whether a reversal is pending,
    // how many beats the owner has sent, and what sits in the one-beat pipe.
    int            m_owner;    // 0 nobody, 1 A, 2 B
    bit            m_turning;
    int            m_target;
    int            m_gap;
    int            m_sent;
    int            m_pri;
    bit            m_have;
    int            m_to;       // 1 toward A, 2 toward B
    logic [DW-1:0] m_last_a;
    logic [DW-1:0] m_last_b;

    // snapshot of DUT outputs taken at the last compare point
    logic          s_ar, s_br, s_aov, s_bov, s_dab, s_dba;
    logic [DW-1:0] s_ad, s_bd;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_turning = 0;
        m_target  = 0;
        m_gap     = 0;
        m_sent    = 0;
        m_pri     = 1;
        m_have    = 0;
        m_to      = 0;
        m_last_a  = '0;
        m_last_b  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_a_in_ready"}, a_in_ready, 1'b0);
        chk1({tag, "_b_in_ready"}, b_in_ready, 1'b0);
        chk1({tag, "_a_out_valid"}, a_out_valid, 1'b0);
        chk1({tag, "_b_out_valid"}, b_out_valid, 1'b0);
        chkd({tag, "_a_out_data"}, a_out_data, '0);
        chkd({tag, "_b_out_data"}, b_out_data, '0);
        chk1({tag, "_dir_a2b"}, dir_a2b, 1'b0);
        chk1({tag, "_dir_b2a"}, dir_b2a, 1'b0);
    endtask

    // Called shortly after a falling edge: assert reset asynchronously,
    // check the outputs clear immediately, release on a later falling edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One link cycle: drive inputs, compare every output with the model,
    // advance the model across the coming rising edge.
    task automatic cycle(input bit av, input logic [DW-1:0] ad, input bit bv,
                         input logic [DW-1:0] bd, input bit aor, input bit bor);
        bit owned_a, owned_b, stall_a, stall_b;
        bit e_ar, e_br, e_aov, e_bov, e_dab, e_dba;
        bit acc_a, acc_b, pop, had;
        a_in_valid  = av;
        a_in_data   = ad;
        b_in_valid  = bv;
        b_in_data   = bd;
        a_out_ready = aor;
        b_out_ready = bor;
        #1;
        owned_a = (m_owner == 1) && !m_turning;
        owned_b = (m_owner == 2) && !m_turning;
        stall_a = owned_a && bv && ((m_sent == MB) || !av);
        stall_b = owned_b && av && ((m_sent == MB) || !bv);
        e_ar    = owned_a && !stall_a && (!m_have || bor);
        e_br    = owned_b && !stall_b && (!m_have || aor);
        e_aov   = m_have && (m_to == 1);
        e_bov   = m_have && (m_to == 2);
        e_dab   = owned_a || (m_turning && e_bov);
        e_dba   = owned_b || (m_turning && e_aov);

        s_ar = a_in_ready;  s_br = b_in_ready;
        s_aov = a_out_valid; s_bov = b_out_valid;
        s_ad = a_out_data;  s_bd = b_out_data;
        s_dab = dir_a2b;    s_dba = dir_b2a;

        chk1("a_in_ready", s_ar, e_ar);
        chk1("b_in_ready", s_br, e_br);
        chk1("a_out_valid", s_aov, e_aov);
        chk1("b_out_valid", s_bov, e_bov);
        chkd("a_out_data", s_ad, m_last_a);
        chkd("b_out_data", s_bd, m_last_b);
        chk1("dir_a2b", s_dab, e_dab);
        chk1("dir_b2a", s_dba, e_dba);

        acc_a = e_ar && av;
        acc_b = e_br && bv;
        pop   = m_have && ((m_to == 2) ? bor : aor);
        had   = m_have;
        if (acc_a) begin
            m_have = 1; m_to = 2; m_last_b = ad;
        end else if (acc_b) begin
            m_have = 1; m_to = 1; m_last_a = bd;
        end else if (pop) begin
            m_have = 0;
        end
        if ((acc_a || acc_b) && (m_sent < MB)) m_sent++;

        if (m_owner == 0) begin
            if (av && (!bv || m_pri == 1)) begin
                m_owner = 1; m_sent = 0;
            end else if (bv) begin
                m_owner = 2; m_sent = 0;
            end
        end else if (!m_turning) begin
            if (stall_a || stall_b) begin
                m_turning = 1;
                m_target  = stall_a ? 2 : 1;
                m_pri     = m_target;
                m_gap     = (TC > 0) ? TC : 1;
            end
        end else if (!had) begin
            m_gap--;
            if (m_gap == 0) begin
                m_turning = 0;
                m_owner   = m_target;
                m_sent    = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1;
        check_all_zero("por");
        do_reset("rst0");

        // A alone: five beats, one cycle latency, link stays with A
        cycle(1, 32'h1, 0, 0, 1, 1);
        chk1("s1_idle_no_accept", s_ar, 1'b0);
        cycle(1, 32'h1, 0, 0, 1, 1);
        chk1("s1_first_accept", s_ar, 1'b1);
        chk1("s1_dir_a2b", s_dab, 1'b1);
        cycle(1, 32'h2, 0, 0, 1, 1);
        chk1("s1_lat_valid", s_bov, 1'b1);
        chkd("s1_lat_data", s_bd, 32'h1);
        cycle(1, 32'h3, 0, 0, 1, 1);
        cycle(1, 32'h4, 0, 0, 1, 1);
        cycle(1, 32'h5, 0, 0, 1, 1);
        chkd("s1_beat4", s_bd, 32'h4);
        cycle(0, 0, 0, 0, 1, 1);
        chkd("s1_beat5", s_bd, 32'h5);
        cycle(0, 0, 0, 0, 1, 1);
        chk1("s1_empty", s_bov, 1'b0);
        chkd("s1_hold_data", s_bd, 32'h5);
        chk1("s1_sticky", s_dab, 1'b1);

        // both request from reset, burst limit 2, one gap cycle
        do_reset("rst1");
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_idle_a", s_ar, 1'b0);
        chk1("s2_idle_b", s_br, 1'b0);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_a_wins", s_ar, 1'b1);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_a_beat2", s_ar, 1'b1);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_limit_stall", s_ar, 1'b0);
        chk1("s2_drain_dir", s_dab, 1'b1);
        chkd("s2_last_a_beat", s_bd, 32'h1);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_gap_dab", s_dab, 1'b0);
        chk1("s2_gap_dba", s_dba, 1'b0);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_b_owns", s_br, 1'b1);
        chk1("s2_dir_b2a", s_dba, 1'b1);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chkd("s2_b_data", s_ad, 32'h2);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        chk1("s2_b_stall", s_br, 1'b0);
        cycle(1, 32'h1, 1, 32'h2, 1, 1);
        cycle(1, 32'h10, 0, 0, 1, 0);
        chk1("s2_back_to_a", s_ar, 1'b1);

        // stage full, B waiting, destination stalled: DRAIN holds
        cycle(0, 0, 1, 32'h20, 1, 0);
        chk1("s3_full_valid", s_bov, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 32'h20, 1, 0);
            chk1("s3_hold_dir", s_dab, 1'b1);
            chk1("s3_hold_no_b", s_br, 1'b0);
        end
        cycle(0, 0, 1, 32'h20, 1, 1);
        chkd("s3_release_data", s_bd, 32'h10);
        cycle(0, 0, 1, 32'h20, 1, 1);
        chk1("s3_gap", s_dba, 1'b0);
        cycle(0, 0, 1, 32'h20, 1, 1);
        chk1("s3_b2a", s_br, 1'b1);

        // A goes quiet below its burst limit while B waits
        do_reset("rst2");
        cycle(1, 32'h30, 0, 0, 1, 1);
        cycle(1, 32'h30, 0, 0, 1, 1);
        cycle(0, 0, 1, 32'h40, 1, 1);
        chk1("s4_early_yield", s_ar, 1'b0);
        chk1("s4_dir", s_dab, 1'b1);
        cycle(0, 0, 1, 32'h40, 1, 1);
        cycle(0, 0, 1, 32'h40, 1, 1);
        chk1("s4_b_owns", s_br, 1'b1);

        // sole requester keeps the link for 20 beats
        do_reset("rst3");
        cycle(1, 32'h100, 0, 0, 1, 1);
        for (int k = 0; k < 20; k++) begin
            cycle(1, DW'(32'h100 + k), 0, 0, 1, 1);
            chk1("s5_ready", s_ar, 1'b1);
            chk1("s5_no_b2a", s_dba, 1'b0);
            if (k > 0) chkd("s5_data", s_bd, DW'(32'h100 + k - 1));
        end

        // reset with a beat still held in the stage
        chk1("s6_stage_full", b_out_valid, 1'b1);
        do_reset("rst_mid");
        cycle(1, 32'h7, 1, 32'h8, 1, 1);
        chk1("s6_idle", s_ar, 1'b0);
        chk1("s6_no_stale", s_bov, 1'b0);
        cycle(1, 32'h7, 1, 32'h8, 1, 1);
        chk1("s6_prio_a", s_ar, 1'b1);

        // randomized traffic, request bias varies per segment
        for (int seg = 0; seg < 15; seg++) begin
            int pa, pb, pr;
            pa = $urandom_range(10, 95);
            pb = $urandom_range(10, 95);
            pr = $urandom_range(40, 100);
            for (int c = 0; c < 200; c++) begin
                cycle($urandom_range(0, 99) < pa, $urandom, $urandom_range(0, 99) < pb,
                      $urandom, $urandom_range(0, 99) < pr, $urandom_range(0, 99) < pr);
                if (s_dab && s_dba) chk1("dir_exclusive", 1'b1, 1'b0);
            end
            if (seg == 7) do_reset("rst_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
